// File: rtl/life_gen_ctrl_pkg.sv
// life_pkg: grid geometry and FSM state encoding shared by the life generation controller.
package life_pkg;
    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int CELLS = GRID_W * GRID_H;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_WAIT   = 2'd1;
    localparam state_t S_SETTLE = 2'd2;
    localparam state_t S_COMMIT = 2'd3;
endpackage

// File: rtl/life_gen_ctrl_if.sv
// life_gen_ctrl_if: control, load and board signals between the controller and its environment.
interface life_gen_ctrl_if;
    import life_pkg::*;
    logic             run;
    logic             step;
    logic             load_req;
    logic [CELLS-1:0] load_data;
    logic [CELLS-1:0] next;
    logic [CELLS-1:0] board;
    logic             load_ack;
    logic             commit;
    logic [15:0]      gen_count;
    logic             busy;
    logic             stable;
    modport master (output run, step, load_req, load_data, next,
                    input  board, load_ack, commit, gen_count, busy, stable);
    modport slave  (input  run, step, load_req, load_data, next,
                    output board, load_ack, commit, gen_count, busy, stable);
endinterface

// File: rtl/life_tick_div.sv
// life_tick_div: loadable down-counter timing the WAIT and SETTLE phases; done_o when it reaches zero.
module life_tick_div
    import life_pkg::*;
#(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= clr_i ? '0 : ld_i ? val_i : cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    assign done_o = cnt_q == '0;
endmodule

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: paces Game-of-Life generations (run/step/load) and commits the external next board.
// Define LIFE_STILL_DETECT_EN to pause and flag stable when a commit would not change the board.
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int TICK_DIV      = 50000000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    life_gen_ctrl_if.slave bus
);
    localparam int CW = 26;
    state_t           state_q, state_d;
    logic [CELLS-1:0] board_q;
    logic [15:0]      gen_q;
    logic             ack_q, commit_q, busy_q, stable_q;
    logic             done, ld, still, do_commit;
    logic [CW-1:0]    ld_val;
`ifdef LIFE_STILL_DETECT_EN
    assign still = bus.next == board_q;
`else
    assign still = 1'b0;
`endif
    always_comb begin
        do_commit = state_q == S_COMMIT && !still;
        case (state_q)
            S_IDLE:   state_d = bus.run ? S_WAIT : bus.step ? S_SETTLE : S_IDLE;
            S_WAIT:   state_d = !bus.run ? S_IDLE : done ? S_SETTLE : S_WAIT;
            S_SETTLE: state_d = done ? S_COMMIT : S_SETTLE;
            default:  state_d = bus.run && !still ? S_WAIT : S_IDLE;
        endcase
        if (bus.load_req) state_d = S_IDLE;
        // the counter is reloaded only on entry, so each phase lasts exactly its programmed length
        ld = state_d != state_q && (state_d == S_WAIT || state_d == S_SETTLE);
        ld_val = state_d == S_WAIT ? CW'(TICK_DIV - 1) : CW'(SETTLE_CYCLES - 1);
    end
    life_tick_div #(.W(CW)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (bus.load_req),
        .ld_i   (ld),
        .val_i  (ld_val),
        .done_o (done)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            gen_q    <= '0;
            ack_q    <= 1'b0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= bus.load_req;
            commit_q <= do_commit && !bus.load_req;
            busy_q   <= state_d != S_IDLE;
            if (bus.load_req) begin
                board_q  <= bus.load_data;
                gen_q    <= '0;
                stable_q <= 1'b0;
            end else if (do_commit) begin
                board_q  <= bus.next;
                gen_q    <= gen_q + 1'b1;
                stable_q <= 1'b0;
            end else if (still && state_q == S_COMMIT) stable_q <= 1'b1;
        end
    assign bus.board     = board_q;
    assign bus.gen_count = gen_q;
    assign bus.load_ack  = ack_q;
    assign bus.commit    = commit_q;
    assign bus.busy      = busy_q;
    assign bus.stable    = stable_q;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: directed and randomized checks of life_gen_ctrl against a Game-of-Life reference model.
module tb_life_gen_ctrl;
    import life_pkg::*;
    localparam int T = 4;
    localparam int S = 2;
    localparam int P = T + S + 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    life_gen_ctrl_if bus ();
    life_gen_ctrl #(.TICK_DIV(T), .SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int errs = 0;
    int checks = 0;
    logic [CELLS-1:0] mb, blinker, vert, blk;
    logic [15:0] mg;

    function automatic logic [CELLS-1:0] life_next(input logic [CELLS-1:0] b);
        logic [CELLS-1:0] n;
        n = '0;
        for (int r = 0; r < GRID_H; r++)
            for (int c = 0; c < GRID_W; c++) begin
                int k;
                k = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < GRID_H && c + dc >= 0 && c + dc < GRID_W)
                            k += int'(b[(r + dr) * GRID_W + c + dc]);
                n[r * GRID_W + c] = k == 3 || (k == 2 && b[r * GRID_W + c]);
            end
        return n;
    endfunction

    always_comb bus.next = life_next(bus.board);

    task automatic chk(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_commit(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.commit && n < 100);
        chk("commit_seen", CELLS'(bus.commit), CELLS'(1'b1));
    endtask

    task automatic quiet(input string tag, input int n);
        int c;
        c = 0;
        repeat (n) begin
            tick(1);
            c += int'(bus.commit);
        end
        chk(tag, CELLS'(c), CELLS'(0));
    endtask

    task automatic after_commit(input string tag, input int n, input int exp_n);
        mb = life_next(mb);
        mg = mg + 16'd1;
        chk({tag, "_lat"}, CELLS'(n), CELLS'(exp_n));
        chk({tag, "_board"}, bus.board, mb);
        chk({tag, "_gen"}, CELLS'(bus.gen_count), CELLS'(mg));
        chk({tag, "_stable"}, CELLS'(bus.stable), CELLS'(1'b0));
    endtask

    task automatic do_load(input logic [CELLS-1:0] d);
        bus.load_req = 1'b1;
        bus.load_data = d;
        bus.run = 1'b0;
        tick(1);
        mb = d;
        mg = '0;
        chk("load_board", bus.board, d);
        chk("load_ack", CELLS'(bus.load_ack), CELLS'(1'b1));
        chk("load_gen", CELLS'(bus.gen_count), CELLS'(0));
        chk("load_busy", CELLS'(bus.busy), CELLS'(1'b0));
        chk("load_commit", CELLS'(bus.commit), CELLS'(1'b0));
        bus.load_req = 1'b0;
        tick(1);
        chk("load_ack_drop", CELLS'(bus.load_ack), CELLS'(1'b0));
    endtask

    task automatic run_gens(input int k);
        int n;
        bus.run = 1'b1;
        for (int i = 0; i < k; i++) begin
            wait_commit(n);
            after_commit("run", n, i == 0 ? P + 1 : P);
            chk("run_busy", CELLS'(bus.busy), CELLS'(1'b1));
        end
        bus.run = 1'b0;
        quiet("run_stop", P + 2);
        chk("run_idle", CELLS'(bus.busy), CELLS'(1'b0));
    endtask

    task automatic step_gens(input int k, input bit dbl);
        int n;
        for (int i = 0; i < k; i++) begin
            bus.step = 1'b1;
            tick(1);
            bus.step = dbl && i == 1;
            wait_commit(n);
            bus.step = 1'b0;
            after_commit("step", n, S + 1);
            quiet("step_gap", 6);
        end
    endtask

    initial begin
        int nr;
        logic [CELLS-1:0] d;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.load_req = 1'b0;
        bus.load_data = '0;
        blinker = '0;
        blinker[17] = 1'b1; blinker[18] = 1'b1; blinker[19] = 1'b1;
        vert = '0;
        vert[2] = 1'b1; vert[18] = 1'b1; vert[34] = 1'b1;
        blk = '0;
        blk[17] = 1'b1; blk[18] = 1'b1; blk[33] = 1'b1; blk[34] = 1'b1;
        #12;
        chk("rst_board", bus.board, '0);
        chk("rst_gen", CELLS'(bus.gen_count), CELLS'(0));
        chk("rst_outs", CELLS'({bus.load_ack, bus.commit, bus.busy, bus.stable}), CELLS'(0));
        @(negedge clk) rst_n = 1'b1;
        tick(2);
        chk("post_rst_busy", CELLS'(bus.busy), CELLS'(1'b0));
        do_load(blinker);
        chk("blink_seed", bus.board, CELLS'(32'h000E_0000));
        run_gens(3);
        chk("blink_final", bus.board, vert);
        chk("blink_gen", CELLS'(bus.gen_count), CELLS'(3));
        do_load(blinker);
        step_gens(3, 1'b1);
        chk("step_gen", CELLS'(bus.gen_count), CELLS'(3));
        chk("step_board", bus.board, vert);
        d = {8{$urandom()}};
        bus.run = 1'b1;
        tick(5);
        do_load(d);
        quiet("midgen_nocommit", P + 2);
        chk("midgen_board", bus.board, d);
        chk("midgen_gen", CELLS'(bus.gen_count), CELLS'(0));
        for (int it = 0; it < 5; it++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            do_load(d);
            nr = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) run_gens(nr);
            else step_gens(nr, 1'b0);
        end
        do_load(blk);
`ifdef LIFE_STILL_DETECT_EN
        bus.run = 1'b1;
        tick(P + 1);
        chk("still_stable", CELLS'(bus.stable), CELLS'(1'b1));
        chk("still_busy", CELLS'(bus.busy), CELLS'(1'b0));
        quiet("still_nocommit", P + 1);
        chk("still_gen", CELLS'(bus.gen_count), CELLS'(0));
        chk("still_board", bus.board, blk);
        bus.run = 1'b0;
`else
        run_gens(1);
        chk("block_board", bus.board, blk);
`endif
        bus.run = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_board", bus.board, '0);
        chk("arst_gen", CELLS'(bus.gen_count), CELLS'(0));
        chk("arst_outs", CELLS'({bus.load_ack, bus.commit, bus.busy, bus.stable}), CELLS'(0));
        bus.run = 1'b0;
        #3;
        rst_n = 1'b1;
        tick(1);
        do_load(blinker);
        force dut.gen_q = 16'hFFFF;
        tick(1);
        release dut.gen_q;
        tick(1);
        chk("wrap_preload", CELLS'(bus.gen_count), CELLS'(16'hFFFF));
        mg = 16'hFFFF;
        step_gens(1, 1'b0);
        chk("wrap_zero", CELLS'(bus.gen_count), CELLS'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
